// File: rtl/input_feed_ctrl_pkg.sv
// Shared types and helpers for the systolic-array input feed controller.
// Contents:
//   feed_state_e      - controller FSM states
//   SHIFTER_DELAY_MAX - largest delay the 8-bit shifter delay counter can hold
//   feed_cycles_f     - out_en length per tile for a given array width and DSP depth
package input_feed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_LOAD = 2'd2,
    ST_FEED = 2'd3
  } feed_state_e;

  localparam int unsigned SHIFTER_DELAY_MAX = 255;

  // Skewed lanes drain after the deepest lane's delay plus one column per row.
  function automatic int unsigned feed_cycles_f(input int unsigned w, input int unsigned dspd);
    return (dspd - 1) * (w - 1) + 2 * w - 1;
  endfunction

endpackage

// File: rtl/feed_counter.sv
// Loadable down-counter with a terminal-count flag.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (count -> 0)
//   load_i      - load load_val_i (has priority over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement by one; saturates at zero
//   tc_o        - count is zero
module feed_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/input_feed_ctrl.sv
// Input feed controller for the systolic array row shifters.
// Per tile: one shift_rst cycle, W column loads over a valid/ready stream
// (load_en + lane_data), then FEED_CYCLES of out_en and a tile_done pulse.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - column beat valid
//   in_ready   - controller accepts a column beat (LOAD state only)
//   in_data    - column, lane k in bits [(k+1)*DW-1 : k*DW]
//   shift_rst  - lane clear, high for the single CLR cycle
//   load_en    - registered load strobe, one cycle per accepted beat
//   lane_data  - registered column matching load_en
//   out_en     - registered shifter output enable for FEED_CYCLES cycles
//   busy       - controller not idle
//   tile_done  - one-cycle pulse after the last out_en
module input_feed_ctrl
  import input_feed_ctrl_pkg::*;
#(
  parameter int unsigned W    = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned DSPD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W*DW-1:0] in_data,
  output logic            shift_rst,
  output logic            load_en,
  output logic [W*DW-1:0] lane_data,
  output logic            out_en,
  output logic            busy,
  output logic            tile_done
);

  localparam int unsigned FEED_CYCLES = feed_cycles_f(W, DSPD);
  localparam int unsigned BCW         = $clog2(W + 1);
  localparam int unsigned FCW         = $clog2(FEED_CYCLES + 1);

  if (FEED_CYCLES > SHIFTER_DELAY_MAX) begin : g_feed_len_check
    $error("input_feed_ctrl: FEED_CYCLES exceeds the shifter 8-bit delay counter");
  end

  feed_state_e     state_q, state_d;
  logic [W*DW-1:0] lane_data_q, lane_data_d;
  logic            load_en_q, load_en_d;
  logic            out_en_q, out_en_d;
  logic            tile_done_q, tile_done_d;

  logic beat_load, beat_dec, beat_last;
  logic feed_load, feed_dec, feed_end;
  logic handshake;

  // Beat counter holds beats remaining after the current one, so the
  // terminal count marks the W-th handshake.
  feed_counter #(.WIDTH(BCW)) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (beat_load),
    .load_val_i (BCW'(W - 1)),
    .dec_i      (beat_dec),
    .tc_o       (beat_last)
  );

  feed_counter #(.WIDTH(FCW)) u_feed_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (feed_load),
    .load_val_i (FCW'(FEED_CYCLES)),
    .dec_i      (feed_dec),
    .tc_o       (feed_end)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign shift_rst = (state_q == ST_CLR);
  assign busy      = (state_q != ST_IDLE);
  assign handshake = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    lane_data_d = lane_data_q;
    load_en_d   = 1'b0;
    out_en_d    = 1'b0;
    tile_done_d = 1'b0;
    beat_load   = 1'b0;
    beat_dec    = 1'b0;
    feed_load   = 1'b0;
    feed_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_CLR;
      end
      ST_CLR: begin
        beat_load = 1'b1;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        if (handshake) begin
          lane_data_d = in_data;
          load_en_d   = 1'b1;
          beat_dec    = 1'b1;
          if (beat_last) begin
            feed_load = 1'b1;
            state_d   = ST_FEED;
          end
        end
      end
      ST_FEED: begin
        // The first FEED cycle coincides with the last load_en, so out_en
        // (registered) starts one cycle later and never overlaps it.
        if (!feed_end) begin
          out_en_d = 1'b1;
          feed_dec = 1'b1;
        end else begin
          tile_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lane_data_q <= '0;
      load_en_q   <= 1'b0;
      out_en_q    <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_data_q <= lane_data_d;
      load_en_q   <= load_en_d;
      out_en_q    <= out_en_d;
      tile_done_q <= tile_done_d;
    end
  end

  assign load_en   = load_en_q;
  assign lane_data = lane_data_q;
  assign out_en    = out_en_q;
  assign tile_done = tile_done_q;

endmodule

// File: tb/tb_input_feed_ctrl.sv
module tb_input_feed_ctrl;

  localparam int W    = 4;
  localparam int DW   = 8;
  localparam int DSPD = 4;
  localparam int FC   = (DSPD - 1) * (W - 1) + 2 * W - 1;
  localparam int W2    = 2;
  localparam int DSPD2 = 1;
  localparam int FC2   = (DSPD2 - 1) * (W2 - 1) + 2 * W2 - 1;
  localparam int MAXC  = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [W*DW-1:0] in_data = '0;
  logic            in_ready, shift_rst, load_en, out_en, busy, tile_done;
  logic [W*DW-1:0] lane_data;

  logic             rst2 = 1'b1;
  logic             v2 = 1'b0;
  logic [W2*DW-1:0] d2 = '0;
  logic             in_ready2, shift_rst2, load_en2, out_en2, busy2, tile_done2;
  logic [W2*DW-1:0] lane_data2;

  input_feed_ctrl #(.W(W), .DW(DW), .DSPD(DSPD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_rst(shift_rst), .load_en(load_en), .lane_data(lane_data), .out_en(out_en),
    .busy(busy), .tile_done(tile_done)
  );

  input_feed_ctrl #(.W(W2), .DW(DW), .DSPD(DSPD2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(v2), .in_ready(in_ready2), .in_data(d2),
    .shift_rst(shift_rst2), .load_en(load_en2), .lane_data(lane_data2), .out_en(out_en2),
    .busy(busy2), .tile_done(tile_done2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cols [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

  // Stimulus pattern and expected waveform, one entry per cycle.
  bit          vpat    [MAXC];
  logic [31:0] dpat    [MAXC];
  bit          e_ready [MAXC];
  bit          e_srst  [MAXC];
  bit          e_load  [MAXC];
  bit          e_out   [MAXC];
  bit          e_done  [MAXC];
  bit          e_busy  [MAXC];
  logic [31:0] e_lane  [MAXC];

  // Schedule model: a tile starts at the first idle cycle with valid high,
  // clears for one cycle, accepts the next W valid beats, then feeds FC
  // cycles starting two cycles after the last accepted beat.
  task automatic build_expect(input int n, output int tiles);
    int cur, s, c, k, last;
    logic [31:0] held;
    for (int i = 0; i < n; i++) begin
      e_ready[i] = 0; e_srst[i] = 0; e_load[i] = 0; e_out[i] = 0;
      e_done[i] = 0; e_busy[i] = 0; e_lane[i] = '0;
    end
    tiles = 0;
    cur = 0;
    while (cur < n) begin
      s = cur;
      while (s < n && !vpat[s]) s++;
      if (s + 1 >= n) break;
      e_srst[s + 1] = 1;
      e_busy[s + 1] = 1;
      k = 0;
      c = s + 2;
      while (k < W && c < n) begin
        e_ready[c] = 1;
        e_busy[c]  = 1;
        if (vpat[c]) begin
          if (c + 1 < n) e_load[c + 1] = 1;
          k++;
        end
        c++;
      end
      if (k < W) break;
      last = c - 1;
      for (int j = last + 1; j <= last + 1 + FC && j < n; j++) e_busy[j] = 1;
      for (int j = last + 2; j <= last + 1 + FC && j < n; j++) e_out[j] = 1;
      if (last + 2 + FC < n) begin
        e_done[last + 2 + FC] = 1;
        tiles++;
      end
      cur = last + 2 + FC;
    end
    held = '0;
    for (int i = 0; i < n; i++) begin
      if (e_load[i]) held = dpat[i - 1];
      e_lane[i] = held;
    end
  endtask

  // Called at the falling edge of cycle 0 with the DUT idle and lane_data 0.
  task automatic run_pattern(input int n, input string tag, output int tiles);
    build_expect(n, tiles);
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (in_ready !== e_ready[c]) begin
        n_fail++; $display("FAIL %s in_ready cycle %0d: got %b exp %b", tag, c, in_ready, e_ready[c]);
      end
      n_checks++;
      if (shift_rst !== e_srst[c]) begin
        n_fail++; $display("FAIL %s shift_rst cycle %0d: got %b exp %b", tag, c, shift_rst, e_srst[c]);
      end
      n_checks++;
      if (load_en !== e_load[c]) begin
        n_fail++; $display("FAIL %s load_en cycle %0d: got %b exp %b", tag, c, load_en, e_load[c]);
      end
      n_checks++;
      if (lane_data !== e_lane[c]) begin
        n_fail++; $display("FAIL %s lane_data cycle %0d: got %h exp %h", tag, c, lane_data, e_lane[c]);
      end
      n_checks++;
      if (out_en !== e_out[c]) begin
        n_fail++; $display("FAIL %s out_en cycle %0d: got %b exp %b", tag, c, out_en, e_out[c]);
      end
      n_checks++;
      if (busy !== e_busy[c]) begin
        n_fail++; $display("FAIL %s busy cycle %0d: got %b exp %b", tag, c, busy, e_busy[c]);
      end
      n_checks++;
      if (tile_done !== e_done[c]) begin
        n_fail++; $display("FAIL %s tile_done cycle %0d: got %b exp %b", tag, c, tile_done, e_done[c]);
      end
      in_valid = vpat[c];
      in_data  = dpat[c];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic clear_pattern(input int n);
    for (int i = 0; i < n; i++) begin
      vpat[i] = 0;
      dpat[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; in_valid = 1; in_data = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, shift_rst, load_en, out_en, busy, tile_done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 000000",
                         {in_ready, shift_rst, load_en, out_en, busy, tile_done});
    end
    n_checks++;
    if (lane_data !== '0) begin
      n_fail++; $display("FAIL reset_lane_data: got %h exp 0", lane_data);
    end
    rst = 0; in_valid = 0;
  endtask

  task automatic test_single_tile();
    int t;
    do_reset();
    clear_pattern(40);
    for (int c = 0; c < 6; c++) vpat[c] = 1;
    for (int k = 0; k < 4; k++) dpat[2 + k] = cols[k];
    run_pattern(40, "single", t);
  endtask

  task automatic test_stall();
    int t, k;
    do_reset();
    clear_pattern(50);
    vpat[0] = 1;
    k = 0;
    for (int c = 2; k < 4; c++) begin
      vpat[c] = ((c - 2) % 4 == 0) || ((c - 2) % 4 == 3);
      if (vpat[c]) begin
        dpat[c] = cols[k];
        k++;
      end
    end
    run_pattern(50, "stall", t);
  endtask

  task automatic test_back_to_back();
    int t;
    do_reset();
    clear_pattern(70);
    for (int c = 0; c < 70; c++) vpat[c] = 1;
    run_pattern(70, "b2b", t);
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    in_valid = 1; in_data = cols[0];
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_ready: got %b exp 1", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (load_en !== 1'b1 || lane_data !== cols[0]) begin
      n_fail++; $display("FAIL rstmid_load1: got %b/%h exp 1/%h", load_en, lane_data, cols[0]);
    end
    in_data = cols[1];
    @(negedge clk);
    n_checks++;
    if (load_en !== 1'b1 || lane_data !== cols[1]) begin
      n_fail++; $display("FAIL rstmid_load2: got %b/%h exp 1/%h", load_en, lane_data, cols[1]);
    end
    rst = 1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, shift_rst, load_en, out_en, busy, tile_done} !== 6'b0 || lane_data !== '0) begin
      n_fail++; $display("FAIL rstmid_clear: got %b/%h exp 000000/0",
                         {in_ready, shift_rst, load_en, out_en, busy, tile_done}, lane_data);
    end
    rst = 0;
    clear_pattern(40);
    for (int c = 0; c < 6; c++) vpat[c] = 1;
    for (int k = 0; k < 4; k++) dpat[2 + k] = cols[k];
    run_pattern(40, "rstmid", t);
  endtask

  task automatic test_random();
    int total, t, p;
    total = 0;
    for (int chunk = 0; chunk < 40 && total < 1000; chunk++) begin
      do_reset();
      p = $urandom_range(95, 30);
      for (int c = 0; c < MAXC; c++) begin
        vpat[c] = ($urandom_range(99, 0) < p);
        dpat[c] = $urandom;
      end
      run_pattern(MAXC, "random", t);
      total += t;
    end
    $display("random tiles completed: %0d", total);
  endtask

  task automatic test_narrow();
    logic [15:0] c2 [2];
    int loads, outs, dones, last_load, first_out, done_c;
    c2[0] = 16'hB2A1; c2[1] = 16'hD4C3;
    loads = 0; outs = 0; dones = 0; last_load = -1; first_out = -1; done_c = -1;
    @(negedge clk);
    rst2 = 1; v2 = 0;
    repeat (2) @(negedge clk);
    rst2 = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (load_en2) begin
        n_checks++;
        if (loads < 2 && lane_data2 !== c2[loads]) begin
          n_fail++; $display("FAIL narrow_lane_data beat %0d: got %h exp %h", loads, lane_data2, c2[loads]);
        end
        loads++;
        last_load = c;
      end
      if (out_en2) begin
        outs++;
        if (first_out < 0) first_out = c;
      end
      if (tile_done2) begin
        dones++;
        done_c = c;
      end
      v2 = (c < 4);
      d2 = (c == 2) ? c2[0] : (c == 3) ? c2[1] : 16'($urandom);
    end
    v2 = 0;
    n_checks++;
    if (loads != W2) begin
      n_fail++; $display("FAIL narrow_loads: got %0d exp %0d", loads, W2);
    end
    n_checks++;
    if (outs != FC2) begin
      n_fail++; $display("FAIL narrow_out_len: got %0d exp %0d", outs, FC2);
    end
    n_checks++;
    if (first_out != last_load + 1) begin
      n_fail++; $display("FAIL narrow_out_start: got %0d exp %0d", first_out, last_load + 1);
    end
    n_checks++;
    if (dones != 1 || done_c != first_out + FC2) begin
      n_fail++; $display("FAIL narrow_done: got %0d@%0d exp 1@%0d", dones, done_c, first_out + FC2);
    end
  endtask

  // Continuous invariants on the main instance.
  int run_len = 0;
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      n_checks++;
      if (load_en && out_en) begin
        n_fail++; $display("FAIL inv_load_out: got load_en=%b out_en=%b exp not both 1", load_en, out_en);
      end
      n_checks++;
      if (shift_rst && (load_en || out_en)) begin
        n_fail++; $display("FAIL inv_shift_rst: got shift_rst=%b load_en=%b out_en=%b", shift_rst, load_en, out_en);
      end
      if (out_en) begin
        run_len++;
      end else begin
        if (run_len != 0) begin
          n_checks++;
          if (run_len != FC) begin
            n_fail++; $display("FAIL out_en_run_length: got %0d exp %0d", run_len, FC);
          end
        end
        run_len = 0;
      end
    end
  end

  initial begin
    test_reset();
    test_single_tile();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_narrow();
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
